// File: rtl/mpx_arb_n_1.sv
// N:1 arbitrated multiplexer with a one-word registered output stage.
// MODE 0 is round-robin, MODE 1 is fixed priority (lowest index wins).
module mpx_arb_n_1 #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int MODE     = 0,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_sel
);

  logic [SELW-1:0]     last;
  logic [CHANNELS-1:0] hi_mask;
  logic [CHANNELS-1:0] req_hi;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] pick;
  logic [CHANNELS-1:0] grant;
  logic [SELW-1:0]     gidx;
  logic [WIDTH-1:0]    gdata;
  logic                load;

  // Round-robin: prefer requesters above last, else wrap to the lowest.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hi_mask[i] = (MODE == 0) && (i > int'(last));
    end
    req_hi = in_valid & hi_mask;
    req    = (|req_hi) ? req_hi : in_valid;
    pick   = req & (~req + CHANNELS'(1));
    grant  = rst_n ? pick : '0;
    gidx   = '0;
    gdata  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        gidx  = SELW'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load     = !out_valid || out_ready;
  assign in_ready = load ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SELW'(CHANNELS - 1);
    end else if (load) begin
      out_valid <= |grant;
      if (|grant) begin
        out_data <= gdata;
        out_sel  <= gidx;
        last     <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_mpx_arb_n_1.sv
// Directed bench for mpx_arb_n_1 across four parameter sets.
module tb_mpx_arb_n_1;

  logic clk = 1'b0;
  logic rst_n;
  int   cmp = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // u0: 4 ch round-robin
  logic [63:0] d0;
  logic [3:0]  v0, r0;
  logic [15:0] od0;
  logic        ov0, or0;
  logic [1:0]  os0;
  // u1: 4 ch fixed priority
  logic [63:0] d1;
  logic [3:0]  v1, r1;
  logic [15:0] od1;
  logic        ov1, or1;
  logic [1:0]  os1;
  // u2: 2 ch fixed priority
  logic [31:0] d2;
  logic [1:0]  v2, r2;
  logic [15:0] od2;
  logic        ov2, or2;
  logic [0:0]  os2;
  // u3: 8 ch round-robin
  logic [127:0] d3;
  logic [7:0]   v3, r3;
  logic [15:0]  od3;
  logic         ov3, or3;
  logic [2:0]   os3;

  mpx_arb_n_1 #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0),
    .in_ready(r0), .out_data(od0), .out_valid(ov0),
    .out_ready(or0), .out_sel(os0));
  mpx_arb_n_1 #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1),
    .in_ready(r1), .out_data(od1), .out_valid(ov1),
    .out_ready(or1), .out_sel(os1));
  mpx_arb_n_1 #(.WIDTH(16), .CHANNELS(2), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2),
    .in_ready(r2), .out_data(od2), .out_valid(ov2),
    .out_ready(or2), .out_sel(os2));
  mpx_arb_n_1 #(.WIDTH(16), .CHANNELS(8), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
    .in_ready(r3), .out_data(od3), .out_valid(ov3),
    .out_ready(or3), .out_sel(os3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    v0 = 4'b1111;
    v3 = 8'hff;
    #1;
    cmp++;
    if (r0 !== 4'b0000) begin
      bad++;
      $display("FAIL rst_in_ready got=%b exp=0000", r0);
    end
    cmp++;
    if (r3 !== 8'h00) begin
      bad++;
      $display("FAIL rst_in_ready8 got=%h exp=00", r3);
    end
    cmp++;
    if ({ov0, od0, os0} !== 19'd0) begin
      bad++;
      $display("FAIL rst_out got v=%b d=%h s=%0d exp 0",
               ov0, od0, os0);
    end
    v0 = '0;
    v3 = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    v0  = 4'b0100;
    or0 = 1'b0;
    step();
    cmp++;
    if (ov0 !== 1'b1 || od0 !== 16'hA002 || os0 !== 2'd2) begin
      bad++;
      $display("FAIL ar_load got v=%b d=%h s=%0d exp 1 a002 2",
               ov0, od0, os0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    cmp++;
    if (ov0 !== 1'b0 || od0 !== 16'h0 || os0 !== 2'd0) begin
      bad++;
      $display("FAIL ar_clear got v=%b d=%h s=%0d exp 0 0 0",
               ov0, od0, os0);
    end
    v0 = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    v0  = 4'b1111;
    or0 = 1'b1;
    #1;
    cmp++;
    if (r0 !== 4'b0001) begin
      bad++;
      $display("FAIL rr_first_rdy got=%b exp=0001", r0);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      cmp++;
      if (ov0 !== 1'b1 || os0 !== 2'(k % 4) ||
          od0 !== 16'hA000 + 16'(k % 4)) begin
        bad++;
        $display("FAIL rr_%0d got v=%b s=%0d d=%h exp s=%0d",
                 k, ov0, os0, od0, k % 4);
      end
    end
    v0 = '0;
    step();
  endtask

  task automatic test_backpressure();
    v0  = 4'b0001;
    d0  = {16'hA003, 16'hA002, 16'hA001, 16'h1234};
    or0 = 1'b0;
    step();
    cmp++;
    if (ov0 !== 1'b1 || od0 !== 16'h1234 || os0 !== 2'd0) begin
      bad++;
      $display("FAIL bp_load got v=%b d=%h s=%0d", ov0, od0, os0);
    end
    for (int k = 0; k < 3; k++) begin
      v0 = (k == 0) ? 4'b1110 : (k == 1) ? 4'b0111 : 4'b1011;
      d0 = {4{16'hF000 + 16'(k)}};
      #1;
      cmp++;
      if (r0 !== 4'b0000) begin
        bad++;
        $display("FAIL bp_rdy_%0d got=%b exp=0000", k, r0);
      end
      step();
      cmp++;
      if (ov0 !== 1'b1 || od0 !== 16'h1234 || os0 !== 2'd0) begin
        bad++;
        $display("FAIL bp_hold_%0d got v=%b d=%h s=%0d",
                 k, ov0, od0, os0);
      end
    end
    or0 = 1'b1;
    v0  = 4'b0110;
    d0  = {16'h0, 16'h6666, 16'h5555, 16'h0};
    #1;
    cmp++;
    if (r0 !== 4'b0010) begin
      bad++;
      $display("FAIL bp_release_rdy got=%b exp=0010", r0);
    end
    step();
    cmp++;
    if (ov0 !== 1'b1 || od0 !== 16'h5555 || os0 !== 2'd1) begin
      bad++;
      $display("FAIL bp_next got v=%b d=%h s=%0d exp 1 5555 1",
               ov0, od0, os0);
    end
    v0 = '0;
    step();
  endtask

  task automatic test_drain();
    v0 = 4'b0100;
    d0 = {16'h0, 16'hD002, 16'h0, 16'h0};
    #1;
    cmp++;
    if (r0 !== 4'b0100) begin
      bad++;
      $display("FAIL dr_rdy got=%b exp=0100", r0);
    end
    step();
    cmp++;
    if (ov0 !== 1'b1 || od0 !== 16'hD002 || os0 !== 2'd2) begin
      bad++;
      $display("FAIL dr_load got v=%b d=%h s=%0d", ov0, od0, os0);
    end
    v0 = '0;
    step();
    cmp++;
    if (ov0 !== 1'b0 || od0 !== 16'hD002 || os0 !== 2'd2) begin
      bad++;
      $display("FAIL dr_empty got v=%b d=%h s=%0d exp 0 d002 2",
               ov0, od0, os0);
    end
    v0 = 4'b1100;
    #1;
    cmp++;
    if (r0 !== 4'b1000) begin
      bad++;
      $display("FAIL dr_contend_rdy got=%b exp=1000", r0);
    end
    step();
    cmp++;
    if (ov0 !== 1'b1 || os0 !== 2'd3) begin
      bad++;
      $display("FAIL dr_contend got v=%b s=%0d exp 1 3", ov0, os0);
    end
    v0 = '0;
    step();
  endtask

  task automatic test_fixed();
    v1  = 4'b1010;
    or1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp++;
      if (r1 !== 4'b0010) begin
        bad++;
        $display("FAIL fp_rdy_%0d got=%b exp=0010", k, r1);
      end
      step();
      cmp++;
      if (ov1 !== 1'b1 || os1 !== 2'd1 || od1 !== 16'hA001) begin
        bad++;
        $display("FAIL fp_%0d got v=%b s=%0d d=%h exp 1 1 a001",
                 k, ov1, os1, od1);
      end
    end
    v1 = '0;
  endtask

  task automatic test_corners();
    v2  = 2'b11;
    or2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp++;
      if (r2 !== 2'b01) begin
        bad++;
        $display("FAIL c2_rdy_%0d got=%b exp=01", k, r2);
      end
      step();
      cmp++;
      if (ov2 !== 1'b1 || os2 !== 1'b0 || od2 !== 16'hC000) begin
        bad++;
        $display("FAIL c2_%0d got v=%b s=%0d d=%h exp 1 0 c000",
                 k, ov2, os2, od2);
      end
    end
    v2  = '0;
    v3  = 8'hff;
    or3 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      cmp++;
      if (ov3 !== 1'b1 || os3 !== 3'(k % 8) ||
          od3 !== 16'hB000 + 16'(k % 8)) begin
        bad++;
        $display("FAIL c8_%0d got v=%b s=%0d d=%h exp s=%0d",
                 k, ov3, os3, od3, k % 8);
      end
    end
    v3 = '0;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    d0  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    d1  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    d2  = {16'hC001, 16'hC000};
    for (int i = 0; i < 8; i++) d3[i*16 +: 16] = 16'hB000 + 16'(i);
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1; or3 = 1'b1;
    step();
    test_reset();
    test_async_reset();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_fixed();
    test_corners();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, bad);
    $finish;
  end

endmodule

// File: doc/mpx_arb_n_1.md
MPX_ARB_N_1 -- requirements
Module: mpx_arb_n_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data bits per channel (1..64).
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of input channels (2..8).
REQ-003 The block SHALL have parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority with lowest index winning.
REQ-004 The block SHALL have local parameter SELW = $clog2(CHANNELS).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port in_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port in_valid, input, CHANNELS bits: per-channel data-valid.
REQ-010 Port in_ready, output, CHANNELS bits: per-channel accept.
REQ-011 Port out_data, output, WIDTH bits: registered selected data.
REQ-012 Port out_valid, output, 1 bit: out_data holds an untaken word.
REQ-013 Port out_ready, input, 1 bit: the downstream block accepts out_data.
REQ-014 Port out_sel, output, SELW bits: index of the channel that supplied out_data.

Function
REQ-015 A transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-016 The internal load enable SHALL be load = !out_valid || out_ready.
REQ-017 in_ready SHALL be combinational: in_ready[i] = load && grant[i]; at most one bit SHALL be set; in_ready SHALL be 0 when no in_valid is set.
REQ-018 grant SHALL be one-hot over the requesting channels when any in_valid is set, and all-zero otherwise.
REQ-019 MODE 1: grant SHALL select the lowest-index requesting channel.
REQ-020 MODE 0: the search SHALL start at channel (last + 1) mod CHANNELS and ascend with wrap-around, where last is a SELW-bit register.
REQ-021 MODE 0: last SHALL update to the granted index only on an input transfer, and SHALL hold otherwise.
REQ-022 On an input transfer, out_data, out_sel and out_valid SHALL load the granted data, the granted index and 1 at the next edge (latency 1 cycle).
REQ-023 When load = 1 and no channel is valid, out_valid SHALL go to 0 at the next edge, while out_data and out_sel hold.
REQ-024 While out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL stay stable and in_ready SHALL be all-zero.
REQ-025 An output transfer and an input transfer in the same cycle SHALL replace the word with no bubble, giving sustained throughput of 1 word per cycle.
REQ-026 in_valid or in_data changes on non-granted channels SHALL have no effect on the outputs.
REQ-027 No word SHALL be lost or duplicated: every input transfer SHALL produce exactly one output transfer, in order.

Reset
REQ-028 While rst_n = 0: out_valid = 0, out_data = 0, out_sel = 0, last = CHANNELS-1 (so channel 0 has highest round-robin priority first); in_ready SHALL be 0 because grant is masked during reset.
REQ-029 Reset SHALL act asynchronously and discard any held word; the first edge after release SHALL behave as an empty-output cycle.

Verification (CHANNELS=4, WIDTH=16 unless stated)
REQ-030 Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid, out_data and out_sel are 0 immediately, without waiting for a clock edge.
REQ-031 Round-robin: MODE 0, in_valid=4'b1111 held, data channel i = 16'hA000+i, out_ready=1 -> out_sel sequence is 0,1,2,3,0, out_data is A000, A001, A002, A003, A000, one word per cycle.
REQ-032 Fixed priority: MODE 1, in_valid=4'b1010 held, out_ready=1 -> out_sel stays 1 every cycle and in_ready=4'b0010.
REQ-033 Backpressure: out_valid=1 with out_data=16'h1234, out_ready=0 for 3 cycles with changing inputs -> out_data stays 1234, in_ready=0; out_ready=1 then loads the next grant in the same cycle.
REQ-034 Drain: a single word on channel 2 with out_ready=1 and no further in_valid -> out_valid=1 for exactly one cycle, then 0; last=2, so the next contention between channels 2 and 3 grants channel 3.
REQ-035 Parameter corners: CHANNELS=2, WIDTH=16, MODE=1, in_valid=2'b11 -> channel 0 always wins; CHANNELS=8 round-robin wraps 7 -> 0.
